// File: rtl/inst_mem_loader.sv
// inst_mem_loader: byte-stream program loader for the instruction memory.
// Reads a 16-bit little-endian word count followed by that many
// little-endian words. Each completed word goes out on a one-cycle write
// strobe. The core is held in stall for the whole session.
module inst_mem_loader #(
    parameter int CPU_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load_start,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [CPU_WIDTH-1:0] wr_addr,
    output logic [CPU_WIDTH-1:0] wr_data,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 load_err
);

    // Byte lanes per word. The lane index needs at least one bit.
    localparam int LANES  = CPU_WIDTH / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    // The word index has one extra bit, so a full-depth load never wraps it.
    localparam int IDX_W  = ADDR_WIDTH + 1;
    // Largest legal word count. A full memory is allowed.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t               state_reg,     state_next;
    logic [15:0]          count_reg,     count_next;
    logic [IDX_W-1:0]     word_idx_reg,  word_idx_next;
    logic [LANE_W-1:0]    lane_reg,      lane_next;

    logic                 in_ready_reg,  in_ready_next;
    logic                 wr_en_reg,     wr_en_next;
    logic [CPU_WIDTH-1:0] wr_addr_reg,   wr_addr_next;
    logic [CPU_WIDTH-1:0] wr_data_reg,   wr_data_next;
    logic                 core_hold_reg, core_hold_next;
    logic                 load_done_reg, load_done_next;
    logic                 load_err_reg,  load_err_next;

    logic                 accept;
    logic [15:0]          hdr_count;
    logic                 last_lane;
    logic                 last_word;
    logic [CPU_WIDTH-1:0] word_assembled;

    // A byte moves only when the registered ready meets an offered byte.
    assign accept    = in_valid && in_ready_reg;
    // Full count, formed in the cycle the high header byte arrives.
    assign hdr_count = {in_byte, count_reg[7:0]};
    assign last_lane = (lane_reg == LANE_W'(LANES - 1));
    assign last_word = ((32'(word_idx_reg) + 32'd1) == 32'(count_reg));

    // Lane storage. The lower lanes are captured as they arrive. The top
    // lane comes straight from the input byte, so the write can issue on
    // the very next edge without waiting for another cycle.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi < LANES - 1) begin : g_store
                logic [7:0] lane_byte_reg;
                logic       lane_we;

                assign lane_we = accept && (state_reg == ST_DATA) &&
                                 (lane_reg == LANE_W'(gi));

                // Capture this lane's byte. The value is kept across input stalls.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        lane_byte_reg <= '0;
                    end else if (lane_we) begin
                        lane_byte_reg <= in_byte;
                    end
                end

                assign word_assembled[gi*8 +: 8] = lane_byte_reg;
            end else begin : g_last
                assign word_assembled[gi*8 +: 8] = in_byte;
            end
        end
    endgenerate

    // Next-state logic and next values for all registered outputs.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        word_idx_next  = word_idx_reg;
        lane_next      = lane_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        load_err_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    state_next    = ST_HDR0;
                    word_idx_next = '0;
                    lane_next     = '0;
                end
            end

            ST_HDR0: begin
                if (accept) begin
                    count_next[7:0] = in_byte;
                    state_next      = ST_HDR1;
                end
            end

            ST_HDR1: begin
                if (accept) begin
                    count_next[15:8] = in_byte;
                    if (32'(hdr_count) > MAX_WORDS) begin
                        // Rejected header: abort the session without any write.
                        state_next    = ST_IDLE;
                        load_err_next = 1'b1;
                    end else if (hdr_count == 16'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_DATA;
                        word_idx_next = '0;
                        lane_next     = '0;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    if (last_lane) begin
                        wr_en_next    = 1'b1;
                        wr_data_next  = word_assembled;
                        wr_addr_next  = CPU_WIDTH'({word_idx_reg[ADDR_WIDTH-1:0], 2'b00});
                        word_idx_next = word_idx_reg + IDX_W'(1);
                        lane_next     = '0;
                        if (last_word) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        lane_next = lane_reg + LANE_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // These flags depend only on the upcoming state, so they are
        // registered and never follow in_valid combinationally.
        in_ready_next  = (state_next == ST_HDR0) || (state_next == ST_HDR1) ||
                         (state_next == ST_DATA);
        core_hold_next = (state_next != ST_IDLE);
        load_done_next = (state_next == ST_DONE);
    end

    // State, counters and output registers. Reset clears everything at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            word_idx_reg  <= '0;
            lane_reg      <= '0;
            in_ready_reg  <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            core_hold_reg <= 1'b0;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            word_idx_reg  <= word_idx_next;
            lane_reg      <= lane_next;
            in_ready_reg  <= in_ready_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            core_hold_reg <= core_hold_next;
            load_done_reg <= load_done_next;
            load_err_reg  <= load_err_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign core_hold = core_hold_reg;
    assign load_done = load_done_reg;
    assign load_err  = load_err_reg;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed testbench for inst_mem_loader.
// Instance a uses the default depth and instance b uses ADDR_WIDTH=4.
// The two instances share the byte stream. Each instance has its own
// load_start, so only the instance in session accepts bytes.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        a_ls = 1'b0;
    logic        b_ls = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;

    logic        a_in_ready, a_wr_en, a_core_hold, a_load_done, a_load_err;
    logic [31:0] a_wr_addr, a_wr_data;
    logic        b_in_ready, b_wr_en, b_core_hold, b_load_done, b_load_err;
    logic [31:0] b_wr_addr, b_wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [31:0] a_wa[$], a_wd[$], b_wa[$], b_wd[$];
    int a_wc[$], a_dc[$], a_ec[$], a_fall[$];
    int b_wc[$], b_dc[$], b_ec[$], b_fall[$];
    logic a_hold_prev = 1'b0;
    logic b_hold_prev = 1'b0;

    inst_mem_loader #(.CPU_WIDTH(32), .ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rstn(rstn), .load_start(a_ls), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(a_in_ready), .wr_en(a_wr_en),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .core_hold(a_core_hold),
        .load_done(a_load_done), .load_err(a_load_err)
    );

    inst_mem_loader #(.CPU_WIDTH(32), .ADDR_WIDTH(4)) dut_b (
        .clk(clk), .rstn(rstn), .load_start(b_ls), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(b_in_ready), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .core_hold(b_core_hold),
        .load_done(b_load_done), .load_err(b_load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log output events at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (a_wr_en) begin
            a_wa.push_back(a_wr_addr); a_wd.push_back(a_wr_data); a_wc.push_back(cyc);
            $display("[a] cyc %0d write addr=%h data=%h", cyc, a_wr_addr, a_wr_data);
        end
        if (a_load_done) a_dc.push_back(cyc);
        if (a_load_err) a_ec.push_back(cyc);
        if (a_hold_prev && !a_core_hold) a_fall.push_back(cyc);
        a_hold_prev = a_core_hold;
        if (b_wr_en) begin
            b_wa.push_back(b_wr_addr); b_wd.push_back(b_wr_data); b_wc.push_back(cyc);
            $display("[b] cyc %0d write addr=%h data=%h", cyc, b_wr_addr, b_wr_data);
        end
        if (b_load_done) b_dc.push_back(cyc);
        if (b_load_err) b_ec.push_back(cyc);
        if (b_hold_prev && !b_core_hold) b_fall.push_back(cyc);
        b_hold_prev = b_core_hold;
    end

    task automatic clear_logs();
        a_wa.delete(); a_wd.delete(); a_wc.delete(); a_dc.delete(); a_ec.delete(); a_fall.delete();
        b_wa.delete(); b_wd.delete(); b_wc.delete(); b_dc.delete(); b_ec.delete(); b_fall.delete();
    endtask

    // Pulse load_start on one instance for one clock.
    task automatic start(input bit sel);
        if (sel) b_ls = 1'b1; else a_ls = 1'b1;
        @(posedge clk); #1;
        a_ls = 1'b0; b_ls = 1'b0;
    endtask

    // Offer one byte until it is accepted, then idle for gap cycles.
    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        bit got = 0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if ((sel ? b_in_ready : a_in_ready) === 1'b1) begin
                got = 1;
                last_acc = cyc;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted, required acceptance within 50 cycles", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b1; in_byte = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({a_in_ready, a_wr_en, a_core_hold, a_load_done, a_load_err, a_wr_addr, a_wr_data,
                 b_in_ready, b_wr_en, b_core_hold, b_load_done, b_load_err, b_wr_addr, b_wr_data} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d a ready/wr/hold/done/err=%b%b%b%b%b b=%b%b%b%b%b, required all 0",
                         i, a_in_ready, a_wr_en, a_core_hold, a_load_done, a_load_err,
                         b_in_ready, b_wr_en, b_core_hold, b_load_done, b_load_err);
            end
        end
        @(posedge clk); #1;
        rstn = 1'b1; in_valid = 1'b0;
        settle();
        checks++;
        if (a_wa.size() != 0 || b_wa.size() != 0) begin
            errors++;
            $display("FAIL reset_no_write: writes a=%0d b=%0d, required 0", a_wa.size(), b_wa.size());
        end
    endtask

    // Two-word program. The gap argument inserts idle cycles between bytes.
    task automatic test_two_words(input int gap);
        logic [7:0] v [10];
        v = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        clear_logs();
        start(0);
        for (int i = 0; i < 10; i++) send_byte(0, v[i], gap);
        settle();
        checks++;
        if (a_wa.size() != 2) begin
            errors++;
            $display("FAIL two_words_count(gap %0d): %0d writes, required 2", gap, a_wa.size());
        end else begin
            checks++;
            if (a_wa[0] !== 32'h0 || a_wd[0] !== 32'h00A00513) begin
                errors++;
                $display("FAIL two_words_w0(gap %0d): addr %h data %h, required 00000000 00a00513", gap, a_wa[0], a_wd[0]);
            end
            checks++;
            if (a_wa[1] !== 32'h4 || a_wd[1] !== 32'h00B505B3) begin
                errors++;
                $display("FAIL two_words_w1(gap %0d): addr %h data %h, required 00000004 00b505b3", gap, a_wa[1], a_wd[1]);
            end
            checks++;
            if (a_dc.size() != 1 || a_dc[0] != a_wc[1]) begin
                errors++;
                $display("FAIL two_words_done(gap %0d): %0d done pulses, required one in cycle %0d", gap, a_dc.size(), a_wc[1]);
            end
            checks++;
            if (a_fall.size() != 1 || a_fall[0] != a_wc[1] + 1) begin
                errors++;
                $display("FAIL two_words_hold(gap %0d): %0d hold falls, required one in cycle %0d", gap, a_fall.size(), a_wc[1] + 1);
            end
        end
        checks++;
        if (a_in_ready !== 1'b0 || a_core_hold !== 1'b0 || a_ec.size() != 0) begin
            errors++;
            $display("FAIL two_words_idle(gap %0d): ready %b hold %b errs %0d, required 0 0 0", gap, a_in_ready, a_core_hold, a_ec.size());
        end
    endtask

    task automatic test_header_reject();
        clear_logs();
        start(1);
        send_byte(1, 8'h11, 0);
        send_byte(1, 8'h00, 0);
        checks++;
        if (b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reject_ready: in_ready %b, required 0", b_in_ready);
        end
        settle();
        checks++;
        if (b_ec.size() != 1 || b_ec[0] != last_acc + 1) begin
            errors++;
            $display("FAIL reject_err: %0d error pulses, required one in cycle %0d", b_ec.size(), last_acc + 1);
        end
        checks++;
        if (b_fall.size() != 1 || b_fall[0] != last_acc + 1) begin
            errors++;
            $display("FAIL reject_hold: %0d hold falls, required one in cycle %0d", b_fall.size(), last_acc + 1);
        end
        checks++;
        if (b_wa.size() != 0 || b_dc.size() != 0 || b_core_hold !== 1'b0) begin
            errors++;
            $display("FAIL reject_quiet: writes %0d dones %0d hold %b, required 0 0 0", b_wa.size(), b_dc.size(), b_core_hold);
        end
    endtask

    task automatic test_zero_count();
        clear_logs();
        start(0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h00, 0);
        settle();
        checks++;
        if (a_dc.size() != 1 || a_dc[0] != last_acc + 1) begin
            errors++;
            $display("FAIL zero_done: %0d done pulses, required one in cycle %0d", a_dc.size(), last_acc + 1);
        end
        checks++;
        if (a_wa.size() != 0 || a_core_hold !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet: writes %0d hold %b, required 0 0", a_wa.size(), a_core_hold);
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] exp;
        clear_logs();
        start(1);
        send_byte(1, 8'h10, 0);
        send_byte(1, 8'h00, 0);
        for (int j = 0; j < 64; j++) send_byte(1, 8'(j), 0);
        settle();
        checks++;
        if (b_wa.size() != 16) begin
            errors++;
            $display("FAIL full_count: %0d writes, required 16", b_wa.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
                checks++;
                if (b_wa[i] !== 32'(4*i) || b_wd[i] !== exp) begin
                    errors++;
                    $display("FAIL full_word%0d: addr %h data %h, required %h %h", i, b_wa[i], b_wd[i], 32'(4*i), exp);
                end
            end
            checks++;
            if (b_wa[15] !== 32'h3C) begin
                errors++;
                $display("FAIL full_last_addr: %h, required 0000003c", b_wa[15]);
            end
            checks++;
            if (b_dc.size() != 1 || b_dc[0] != b_wc[15] || b_ec.size() != 0) begin
                errors++;
                $display("FAIL full_done: %0d dones %0d errs, required one done in cycle %0d and no error", b_dc.size(), b_ec.size(), b_wc[15]);
            end
        end
    endtask

    task automatic test_start_ignored();
        clear_logs();
        start(0);
        send_byte(0, 8'h01, 0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        start(0);
        send_byte(0, 8'h33, 0);
        send_byte(0, 8'h44, 0);
        settle();
        checks++;
        if (a_wa.size() != 1 || a_wd[0] !== 32'h44332211 || a_wa[0] !== 32'h0) begin
            errors++;
            $display("FAIL restart_ignored: %0d writes, required one write of 44332211 at 0", a_wa.size());
        end
    endtask

    task automatic test_reset_midsession();
        logic [7:0] v [8];
        v = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        start(0);
        for (int i = 0; i < 8; i++) send_byte(0, v[i], 0);
        rstn = 1'b0; in_valid = 1'b1; in_byte = 8'h77;
        clear_logs();
        @(negedge clk);
        checks++;
        if (a_core_hold !== 1'b0 || a_in_ready !== 1'b0 || a_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: hold %b ready %b wr %b, required 0 0 0", a_core_hold, a_in_ready, a_wr_en);
        end
        @(posedge clk); #1;
        rstn = 1'b1; in_valid = 1'b0;
        settle();
        checks++;
        if (a_wa.size() != 0 || a_core_hold !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: writes %0d hold %b, required 0 0", a_wa.size(), a_core_hold);
        end
        start(0);
        send_byte(0, 8'h01, 0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'hEF, 0);
        send_byte(0, 8'hBE, 0);
        send_byte(0, 8'hAD, 0);
        send_byte(0, 8'hDE, 0);
        settle();
        checks++;
        if (a_wa.size() != 1 || a_wa[0] !== 32'h0 || a_wd[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL midreset_reload: %0d writes, required one write of deadbeef at 0", a_wa.size());
        end
        checks++;
        if (a_dc.size() != 1) begin
            errors++;
            $display("FAIL midreset_done: %0d done pulses, required 1", a_dc.size());
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_two_words(0);
        test_two_words(3);
        test_header_reject();
        test_zero_count();
        test_full_depth();
        test_start_ignored();
        test_reset_midsession();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
